// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: start bit, DATA_BITS data bits LSB-first,
// one stop bit. A byte is accepted over a valid/ready handshake while idle;
// a baud-interval divider times each bit slot and a down-counting bit
// counter tracks the data bits. Every output comes straight from a flop.
module uart_tx_sequencer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t               state_q;
   logic [BAUD_W-1:0]    baud_q;
   logic [BIT_W-1:0]     bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 tx_q;
   logic                 ready_q;
   logic                 busy_q;

   logic                 baud_end;
   logic [DATA_BITS-1:0] shift_d;

   // Last clock of the current bit slot.
   assign baud_end = (baud_q == BAUD_LAST);
   // Shift register contents once the current data bit has been sent.
   assign shift_d  = shift_q >> 1;

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign busy     = busy_q;

   // Frame state machine; drives divider, bit counter, shifter and outputs.
   always_ff @(posedge clk) begin
      // NOTE: all state is updated with non-blocking assignments so every
      // branch below reads the pre-edge values of the other registers.
      if (reset) begin
         // NOTE: the shift register is reset as well, so the datapath never
         // carries X into tx even though it is reloaded on every accept.
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= BIT_LAST;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tx_valid && ready_q) begin
                  shift_q <= tx_data;
                  baud_q  <= '0;
                  state_q <= S_START;
                  tx_q    <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end

            S_START: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end

            S_DATA: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  shift_q <= shift_d;
                  if (bit_q == '0) begin
                     // Reload rather than wrap, ready for the next frame.
                     bit_q   <= BIT_LAST;
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_q <= bit_q - BIT_W'(1);
                     tx_q  <= shift_d[0];
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end

            S_STOP: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end

            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer. One instance at 4 clocks/bit is
// checked every cycle against a frame-level reference model; a second at
// 5 clocks/bit is swept over all 256 bytes through a UART receiver model.
module tb_uart_tx_sequencer;

   localparam int CPB4   = 4;
   localparam int CPB5   = 5;
   localparam int NBITS  = 8;
   localparam int FRAME4 = (NBITS + 2) * CPB4;

   logic clk;

   logic       rst4, valid4, ready4, tx4, busy4;
   logic [7:0] data4;
   logic       rst5, valid5, ready5, tx5, busy5;
   logic [7:0] data5;

   int checks;
   int errors;

   // Reference model state for the 4-clocks/bit instance.
   bit         m_busy;
   int         m_t;
   logic [7:0] m_byte;

   logic hist [0:99];

   uart_tx_sequencer #(.CLKS_PER_BIT(CPB4), .DATA_BITS(NBITS)) dut4 (
      .clk      (clk),
      .reset    (rst4),
      .tx_data  (data4),
      .tx_valid (valid4),
      .tx_ready (ready4),
      .tx       (tx4),
      .busy     (busy4)
   );

   uart_tx_sequencer #(.CLKS_PER_BIT(CPB5), .DATA_BITS(NBITS)) dut5 (
      .clk      (clk),
      .reset    (rst5),
      .tx_data  (data5),
      .tx_valid (valid5),
      .tx_ready (ready5),
      .tx       (tx5),
      .busy     (busy5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Line level of frame slot `slot`: start, data LSB-first, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int slot);
      if (slot == 0)          return 1'b0;
      else if (slot <= NBITS) return b[slot-1];
      else                    return 1'b1;
   endfunction

   // Drive inputs for one edge of dut4, advance the model, compare outputs.
   task automatic step4(input logic r, input logic v, input logic [7:0] d);
      logic exp_tx;
      rst4 = r; valid4 = v; data4 = d;
      @(posedge clk); #1;
      if (r) begin
         m_busy = 1'b0;
      end else if (m_busy) begin
         m_t++;
         if (m_t >= FRAME4) m_busy = 1'b0;
      end else if (v) begin
         m_busy = 1'b1;
         m_t    = 0;
         m_byte = d;
      end
      exp_tx = m_busy ? frame_bit(m_byte, m_t / CPB4) : 1'b1;
      check("tx4", tx4, exp_tx);
      check("ready4", ready4, !m_busy);
      check("busy4", busy4, m_busy);
   endtask

   task automatic tick5(input logic v, input logic [7:0] d);
      valid5 = v; data5 = d;
      @(posedge clk); #1;
   endtask

   // Send one byte on an idle dut4, sample each slot centre, time tx_ready.
   task automatic run_frame(input logic [7:0] b, input logic [9:0] exp_pat, input string tag);
      logic [9:0] pat;
      int first_ready;
      pat = '0;
      first_ready = 0;
      step4(1'b0, 1'b1, b);
      for (int cyc = 2; cyc <= 44; cyc++) begin
         step4(1'b0, 1'b0, 8'h00);
         if ((cyc - 2) % CPB4 == 0 && (cyc - 2) / CPB4 < 10) pat[(cyc - 2) / CPB4] = tx4;
         if (ready4 && first_ready == 0) first_ready = cyc;
      end
      check({tag, "_pattern"}, 32'(pat), 32'(exp_pat));
      check({tag, "_ready_cycle"}, first_ready, 41);
   endtask

   function automatic logic [7:0] decode4(input int start);
      logic [7:0] b;
      for (int k = 0; k < NBITS; k++) b[k] = hist[start + (k + 1) * CPB4 + 1];
      return b;
   endfunction

   initial begin
      int ones, second_start, late_zero, waited;
      int order [256];
      logic [7:0] b, rx;
      logic stop_bit;

      checks = 0; errors = 0;
      m_busy = 1'b0; m_t = 0; m_byte = '0;
      rst4 = 1'b1; valid4 = 1'b0; data4 = '0;
      rst5 = 1'b1; valid5 = 1'b0; data5 = '0;

      // Reset held 3 cycles with tx_valid high: idle outputs, no transfer.
      repeat (3) step4(1'b1, 1'b1, 8'hFF);
      rst5 = 1'b0;
      repeat (2) step4(1'b0, 1'b0, 8'h00);

      // Single frame 0xA5.
      run_frame(8'hA5, 10'b1101001010, "a5");

      // Back-to-back 0x00 then 0xFF with tx_valid held.
      step4(1'b0, 1'b1, 8'h00);
      hist[1] = tx4;
      for (int cyc = 2; cyc <= 42; cyc++) begin
         step4(1'b0, 1'b1, 8'hFF);
         hist[cyc] = tx4;
      end
      for (int cyc = 43; cyc <= 90; cyc++) begin
         step4(1'b0, 1'b0, 8'h00);
         hist[cyc] = tx4;
      end
      ones = 0;
      for (int c = 1; c <= 41; c++) if (hist[c] === 1'b1) ones++;
      second_start = 0;
      for (int c = 37; c <= 90; c++) if (hist[c] === 1'b0 && second_start == 0) second_start = c;
      check("b2b_gap_ones", ones, 5);
      check("b2b_second_start", second_start, 42);
      check("b2b_byte0", decode4(1), 8'h00);
      check("b2b_byte1", decode4(42), 8'hFF);

      // tx_valid pulse with 0x3C at cycle 10 of a frame is ignored.
      step4(1'b0, 1'b1, 8'($urandom));
      late_zero = 0;
      for (int cyc = 2; cyc <= 60; cyc++) begin
         step4(1'b0, cyc == 10, (cyc == 10) ? 8'h3C : 8'h00);
         if (cyc >= 42 && tx4 !== 1'b1) late_zero++;
      end
      check("ignore_no_second_frame", late_zero, 0);

      // Reset mid-DATA aborts the frame; a fresh byte then sends cleanly.
      step4(1'b0, 1'b1, 8'h5A);
      for (int cyc = 2; cyc <= 17; cyc++) step4(1'b0, 1'b0, 8'h00);
      step4(1'b1, 1'b0, 8'h00);
      check("rst_mid_tx", tx4, 1'b1);
      check("rst_mid_ready", ready4, 1'b1);
      repeat (2) step4(1'b0, 1'b0, 8'h00);
      run_frame(8'h81, 10'b1100000010, "b81");

      // Random traffic with occasional resets against the model.
      for (int i = 0; i < 3000; i++)
         step4($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
      step4(1'b1, 1'b0, 8'h00);

      // All 256 bytes, shuffled, through the receiver model at 5 clocks/bit.
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, tmp;
         j = $urandom_range(0, i);
         tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         b = 8'(order[i]);
         repeat ($urandom_range(0, 3)) tick5(1'b0, 8'h00);
         tick5(1'b1, b);
         waited = 0;
         while (tx5 !== 1'b0 && waited < 8) begin
            tick5(1'b0, 8'h00);
            waited++;
         end
         check("rx_start_seen", tx5, 1'b0);
         rx = '0;
         stop_bit = 1'b0;
         for (int s = 1; s <= 50; s++) begin
            tick5(1'b0, 8'h00);
            if (s >= 7 && s <= 42 && (s - 7) % CPB5 == 0) rx[(s - 7) / CPB5] = tx5;
            if (s == 47) stop_bit = tx5;
         end
         check("rx_byte", rx, b);
         check("rx_stop", stop_bit, 1'b1);
         check("rx_ready_after", ready5, 1'b1);
         check("rx_busy_after", busy5, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
